det_event_window_counter: RTL and testbench
===========================================

Name: det_event_window_counter

Overview:
- Downstream consumer of the serial pattern detector's one-cycle `dout` match pulses.
- Counts match pulses inside fixed-length windows that start on a match, and reports each window's count over a valid/ready handshake.
- Raises a sticky alarm when a window's count reaches a threshold, and keeps a saturating lifetime match total.
- Sits between the detector and the status/interrupt logic.

Parameters:
- WINDOW_LEN, 10, window length in clock cycles, trigger cycle included; legal range >= 2.
- CNT_W, 4, width of the per-window count and of rpt_data.
- THRESH, 3, per-window count at or above which alarm is set; must be <= 2^CNT_W-1.
- TOTAL_W, 16, width of the lifetime match total.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous, active-high reset.
- det_in, input, 1, match pulse from the detector's dout; one pulse per cycle high.
- clear, input, 1, synchronous soft clear; same effect as rst, lower priority than rst.
- win_count, output, CNT_W, live count of the open window; 0 when idle.
- total_count, output, TOTAL_W, saturating lifetime count of det_in highs.
- alarm, output, 1, sticky threshold flag.
- rpt_valid, output, 1, report available.
- rpt_ready, input, 1, consumer accepts the report.
- rpt_data, output, CNT_W, final count of the last closed window.
- rpt_ovf, output, 1, sticky: a report was overwritten before it was accepted.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; cyc, win_count, total_count, rpt_data = 0; alarm, rpt_valid, rpt_ovf = 0.
- clear=1 with rst=0: identical effect to reset. det_in on that cycle is ignored, including for total_count.
- FSM states: IDLE and COUNT.
- IDLE with det_in=1: next state COUNT, cyc<=1, win_count<=1. The trigger cycle is window cycle 0.
- IDLE with det_in=0: stay in IDLE.
- COUNT, general cycle:
  - win_count increments on det_in=1 and saturates at 2^CNT_W-1.
  - cyc increments each cycle.
- COUNT, last cycle (cyc==WINDOW_LEN-1):
  - Final value = win_count + det_in, saturated.
  - At that edge: rpt_data<=final, rpt_valid<=1, alarm<=alarm | (final>=THRESH), win_count<=0, cyc<=0, next state IDLE.
  - A window spans exactly WINDOW_LEN cycles.
- A det_in on the cycle after the last window cycle (now IDLE) opens a new window. Back-to-back windows have no gap cycle.
- Report handshake:
  - Transfer occurs on a cycle with rpt_valid & rpt_ready; rpt_valid falls at that edge unless a new window closes on the same edge.
  - Window close while rpt_valid=1 and rpt_ready=1: new data loaded, rpt_valid stays 1, no overrun.
  - Window close while rpt_valid=1 and rpt_ready=0: rpt_data overwritten, rpt_valid stays 1, rpt_ovf<=1.
  - rpt_data is stable while rpt_valid=1 and no close occurs.
- Report latency: rpt_valid is high in the cycle after the last window cycle.
- total_count increments on every det_in=1 in any state, except on rst/clear cycles; saturates at 2^TOTAL_W-1 with no wrap.
- alarm and rpt_ovf clear only on rst or clear.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: DET_WINDOW_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit counter ts_cnt, reset to 0 by rst/clear and wrapping at 2^32.
  - Adds output port rpt_ts [31:0].
  - On the IDLE->COUNT trigger edge, the ts_cnt value of the trigger cycle is latched as window start.
  - At window close, rpt_ts<=latched start alongside rpt_data, following the same overwrite/overrun rules.
  - rpt_ts resets to 0.
- Undefined: no ts_cnt and no rpt_ts port. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with det_in toggling -> all outputs 0, state IDLE, total_count=0 after release.
- Single pulse: det_in=1 at cycle 5 only (defaults) -> win_count=1 during cycles 6..14; rpt_valid=1, rpt_data=1 at cycle 15; alarm=0; total_count=1.
- Threshold: pulses at window cycles 0, 3, 9 -> rpt_data=3, alarm=1 from cycle after close, held through later windows with 0..2 pulses until clear.
- Handshake and overrun:
  - rpt_ready=0, two windows with 2 then 1 pulses -> rpt_data=1, rpt_ovf=1.
  - Repeat with rpt_ready=1 on the second close cycle -> rpt_data=1, rpt_valid=1, rpt_ovf=0.
- Saturation: WINDOW_LEN=20, CNT_W=4, det_in=1 for 20 cycles -> win_count stops at 15, rpt_data=15.
  - Separately: TOTAL_W=4, 20 pulses -> total_count=15.
- Clear mid-window: clear=1 at window cycle 4 with det_in=1 -> next cycle IDLE, win_count=0, no report, alarm=0, total_count=0; the next pulse starts a fresh window.

Source files
------------

// File: rtl/det_event_window_counter.sv
// Windowed match counter: counts detector pulses in fixed windows opened by a match.
// Optional start timestamp per report when DET_WINDOW_TIMESTAMP_EN is defined.
module det_event_window_counter #(
    parameter int WINDOW_LEN = 10,
    parameter int CNT_W      = 4,
    parameter int THRESH     = 3,
    parameter int TOTAL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               det_in,
    input  logic               clear,
    output logic [CNT_W-1:0]   win_count,
    output logic [TOTAL_W-1:0] total_count,
    output logic               alarm,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [CNT_W-1:0]   rpt_data,
    output logic               rpt_ovf
`ifdef DET_WINDOW_TIMESTAMP_EN
    ,
    output logic [31:0]        rpt_ts
`endif
);

    localparam int CYC_W = $clog2(WINDOW_LEN);
    localparam logic [CYC_W-1:0]   LAST    = CYC_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [TOTAL_W-1:0] TOT_MAX = '1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   rpt_data_q, rpt_data_d;
    logic               rpt_valid_q, rpt_valid_d;
    logic               ovf_q, ovf_d;
    logic               alarm_q, alarm_d;
    logic [CNT_W-1:0]   win_inc;
    logic               trigger;
    logic               close;

    assign win_inc = (win_q == CNT_MAX) ? win_q : win_q + CNT_W'(det_in);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        win_d       = win_q;
        total_d     = total_q;
        rpt_data_d  = rpt_data_q;
        rpt_valid_d = rpt_valid_q & ~rpt_ready;
        ovf_d       = ovf_q;
        alarm_d     = alarm_q;
        trigger     = 1'b0;
        close       = 1'b0;

        if (det_in && total_q != TOT_MAX)
            total_d = total_q + TOTAL_W'(1);

        unique case (state_q)
            IDLE: begin
                if (det_in) begin
                    trigger = 1'b1;
                    state_d = COUNT;
                    cyc_d   = CYC_W'(1);
                    win_d   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (cyc_q == LAST) begin
                    close = 1'b1;
                    state_d = IDLE;
                    cyc_d   = '0;
                    win_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                    win_d = win_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // A close overrides any same-edge transfer; overrun only if nothing drained it.
        if (close) begin
            rpt_data_d  = win_inc;
            rpt_valid_d = 1'b1;
            ovf_d       = ovf_q | (rpt_valid_q & ~rpt_ready);
            alarm_d     = alarm_q | (win_inc >= CNT_W'(THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            win_q       <= '0;
            total_q     <= '0;
            rpt_data_q  <= '0;
            rpt_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            win_q       <= win_d;
            total_q     <= total_d;
            rpt_data_q  <= rpt_data_d;
            rpt_valid_q <= rpt_valid_d;
            ovf_q       <= ovf_d;
            alarm_q     <= alarm_d;
        end
    end

`ifdef DET_WINDOW_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] start_q;
    logic [31:0] rpt_ts_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ts_q     <= '0;
            start_q  <= '0;
            rpt_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (trigger)
                start_q <= ts_q;
            if (close)
                rpt_ts_q <= start_q;
        end
    end

    assign rpt_ts = rpt_ts_q;
`endif

    assign win_count   = win_q;
    assign total_count = total_q;
    assign alarm       = alarm_q;
    assign rpt_valid   = rpt_valid_q;
    assign rpt_data    = rpt_data_q;
    assign rpt_ovf     = ovf_q;

endmodule

// File: tb/tb_det_event_window_counter.sv
// Scoreboard bench for det_event_window_counter: expected reports queued at
// stimulus time, popped by a monitor on each accepted transfer.
module tb_det_event_window_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        det_in = 1'b0;
    logic        rpt_ready = 1'b1;
    logic [3:0]  win_count;
    logic [15:0] total_count;
    logic        alarm;
    logic        rpt_valid;
    logic [3:0]  rpt_data;
    logic        rpt_ovf;

    logic        det1 = 1'b0;
    logic        clr1 = 1'b0;
    logic        rdy1 = 1'b1;
    logic [3:0]  win1;
    logic [3:0]  tot1;
    logic        alarm1;
    logic        vld1;
    logic [3:0]  data1;
    logic        ovf1;

`ifdef DET_WINDOW_TIMESTAMP_EN
    logic [31:0] ts0;
    logic [31:0] ts1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] data;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    det_event_window_counter dut (
        .clk(clk), .rst(rst), .det_in(det_in), .clear(clear),
        .win_count(win_count), .total_count(total_count),
        .alarm(alarm), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_data(rpt_data), .rpt_ovf(rpt_ovf)
`ifdef DET_WINDOW_TIMESTAMP_EN
        , .rpt_ts(ts0)
`endif
    );

    det_event_window_counter #(
        .WINDOW_LEN(20), .CNT_W(4), .THRESH(3), .TOTAL_W(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .det_in(det1), .clear(clr1),
        .win_count(win1), .total_count(tot1),
        .alarm(alarm1), .rpt_valid(vld1), .rpt_ready(rdy1),
        .rpt_data(data1), .rpt_ovf(ovf1)
`ifdef DET_WINDOW_TIMESTAMP_EN
        , .rpt_ts(ts1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_rpt(input logic [3:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        q.push_back(e);
    endtask

    task automatic tick(input logic d, input logic r);
        det_in    = d;
        rpt_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic window(input logic [9:0] pat, input logic [9:0] rdy);
        for (int i = 0; i < 10; i++)
            tick(pat[i], rdy[i]);
    endtask

    // A transfer happens at the next posedge whenever valid & ready hold mid-cycle.
    always @(negedge clk) begin
        if (!rst && rpt_valid && rpt_ready) begin
            if (q.size() == 0) begin
                check("unexpected_report", 32'(rpt_data), 32'hFFFF_FFFF);
            end else begin
                mon_e = q.pop_front();
                check("rpt_data", 32'(rpt_data), 32'(mon_e.data));
                check("rpt_ovf_at_xfer", 32'(rpt_ovf), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        // reset with det_in toggling
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            tick(i == 0, 1'b1);
        rst = 1'b0;
        check("rst_win", 32'(win_count), 32'd0);
        check("rst_total", 32'(total_count), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_valid", 32'(rpt_valid), 32'd0);
        check("rst_data", 32'(rpt_data), 32'd0);
        check("rst_ovf", 32'(rpt_ovf), 32'd0);
        check("rst_total_sat", 32'(tot1), 32'd0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // single pulse
        expect_rpt(4'd1, 1'b0);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 9; k++) begin
            check("single_win", 32'(win_count), 32'd1);
            check("single_novalid", 32'(rpt_valid), 32'd0);
            tick(1'b0, 1'b1);
        end
        check("single_valid", 32'(rpt_valid), 32'd1);
        check("single_win_idle", 32'(win_count), 32'd0);
        check("single_alarm", 32'(alarm), 32'd0);
        check("single_total", 32'(total_count), 32'd1);
        tick(1'b0, 1'b1);
        check("single_valid_fall", 32'(rpt_valid), 32'd0);

        // threshold: pulses at window cycles 0,3,9
        expect_rpt(4'd3, 1'b0);
        window(10'b10_0000_1001, 10'h3FF);
        check("thr_alarm", 32'(alarm), 32'd1);
        check("thr_total", 32'(total_count), 32'd4);
        expect_rpt(4'd2, 1'b0);
        window(10'b00_0010_0001, 10'h3FF);
        check("thr_alarm_held", 32'(alarm), 32'd1);
        check("thr_total2", 32'(total_count), 32'd6);
        clear = 1'b1;
        tick(1'b1, 1'b1);
        clear = 1'b0;
        check("clr_alarm", 32'(alarm), 32'd0);
        check("clr_total", 32'(total_count), 32'd0);
        check("clr_valid", 32'(rpt_valid), 32'd0);

        // overrun: two closes with no ready
        expect_rpt(4'd1, 1'b1);
        window(10'b00_0000_0011, 10'h000);
        window(10'b00_0000_0001, 10'h000);
        check("ovr_valid", 32'(rpt_valid), 32'd1);
        check("ovr_flag", 32'(rpt_ovf), 32'd1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("ovr_valid_fall", 32'(rpt_valid), 32'd0);
        check("ovr_sticky", 32'(rpt_ovf), 32'd1);
        clear = 1'b1;
        tick(1'b0, 1'b1);
        clear = 1'b0;
        check("ovr_cleared", 32'(rpt_ovf), 32'd0);

        // ready on the second close cycle: transfer plus reload, no overrun
        expect_rpt(4'd2, 1'b0);
        expect_rpt(4'd1, 1'b0);
        window(10'b00_0000_0011, 10'h000);
        window(10'b00_0000_0001, 10'b10_0000_0000);
        check("xfer_close_valid", 32'(rpt_valid), 32'd1);
        check("xfer_close_ovf", 32'(rpt_ovf), 32'd0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // clear mid-window after an alarm
        expect_rpt(4'd3, 1'b0);
        window(10'b10_0000_1001, 10'h3FF);
        check("mid_alarm_pre", 32'(alarm), 32'd1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        clear = 1'b1;
        tick(1'b1, 1'b1);
        clear = 1'b0;
        check("mid_win", 32'(win_count), 32'd0);
        check("mid_valid", 32'(rpt_valid), 32'd0);
        check("mid_alarm", 32'(alarm), 32'd0);
        check("mid_total", 32'(total_count), 32'd0);
        expect_rpt(4'd1, 1'b0);
        tick(1'b1, 1'b1);
        check("fresh_win", 32'(win_count), 32'd1);
        repeat (9) tick(1'b0, 1'b1);
        check("fresh_valid", 32'(rpt_valid), 32'd1);
        check("fresh_total", 32'(total_count), 32'd1);
        tick(1'b0, 1'b1);

        // saturation on the long-window, narrow-total instance
        det_in = 1'b0;
        det1   = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 14) check("sat_win14", 32'(win1), 32'd14);
            if (i == 15) check("sat_win15", 32'(win1), 32'd15);
            if (i == 19) check("sat_win19", 32'(win1), 32'd15);
        end
        det1 = 1'b0;
        check("sat_valid", 32'(vld1), 32'd1);
        check("sat_data", 32'(data1), 32'd15);
        check("sat_total", 32'(tot1), 32'd15);
        check("sat_alarm", 32'(alarm1), 32'd1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
